fifo_word_unpacker: RTL and testbench

FIFO_WORD_UNPACKER -- requirements
Module: fifo_word_unpacker

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/fifo_word_buf.sv | 68 ++++++
 rtl/fifo_word_unpacker.sv | 153 +++++++++++++++
 tb/tb_fifo_word_unpacker.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble unpacker and its word buffer.
// Nibble count, pad value, FSM states and buffer entry layout.
package fifo_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam logic [3:0] PAD_NIBBLE = 4'hC;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unpack_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cnt;
  } word_ent_t;

  // Counts above a full word mean "the whole word".
  function automatic logic [3:0] clamp_cnt(
    input logic [3:0] c
  );
    return (c > 4'd8) ? 4'd8 : c;
  endfunction

  // True when any nibble beyond the valid count is not the pad value.
  function automatic logic pad_bad(
    input logic [31:0] d,
    input logic [3:0]  c
  );
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
      if ((4'(k) >= c) && (d[4*k +: 4] != PAD_NIBBLE)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/fifo_word_buf.sv
// Synchronous circular word FIFO with wrap-bit pointers.
// Flush clears both pointers; storage itself is never reset.
module fifo_word_buf
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      push_i,
  input  word_ent_t wdata_i,
  input  logic      pop_i,
  output word_ent_t rdata_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [AW:0] level_o
);

  word_ent_t mem_q [DEPTH];

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer next-state; flush wins over push and pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/fifo_word_unpacker.sv
// Buffers packed 32-bit words and streams their nibbles, nibble 0 first.
// Define FIFO_UNPACK_PAD_CHECK_EN to enable the sticky pad_err_o check.
module fifo_word_unpacker
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          word_valid_i,
  input  logic [31:0]   word_data_i,
  input  logic [3:0]    word_cnt_i,
  output logic          word_ready_o,
  output logic          nib_valid_o,
  output logic [3:0]    nib_data_o,
  input  logic          nib_ready_i,
  input  logic          flush_i,
  output logic          fifo_empty_o,
  output logic          fifo_full_o,
  output logic [LW-1:0] level_o,
  output logic          pad_err_o
);

  unpack_state_e state_q;
  logic [2:0]    idx_q;
  logic [31:0]   word_q;
  logic [3:0]    cnt_q;
  logic [3:0]    nib_q;

  logic      buf_full;
  logic      buf_empty;
  word_ent_t head;
  word_ent_t wr_ent;
  logic      push;
  logic      pop;
  logic      last;
  logic      head_live;
  logic [2:0] idx_d;
  logic [3:0] nib_d;
  logic [3:0] cnt_clamped;

  assign cnt_clamped  = clamp_cnt(word_cnt_i);
  assign wr_ent.data  = word_data_i;
  assign wr_ent.cnt   = cnt_clamped;

  assign word_ready_o = !buf_full && !flush_i;
  assign push         = word_valid_i && word_ready_o;

  assign fifo_full_o  = buf_full;
  assign fifo_empty_o = buf_empty && (state_q == ST_IDLE);
  assign nib_valid_o  = (state_q == ST_STREAM);
  assign nib_data_o   = nib_q;

  assign last      = ({1'b0, idx_q} == (cnt_q - 4'd1));
  assign head_live = !buf_empty && (head.cnt != 4'd0);
  assign idx_d     = idx_q + 3'd1;
  assign nib_d     = word_q[{idx_d, 2'b00} +: 4];

  // Pop the head when idle (load or drop it) or to chain after a last nibble.
  always_comb begin
    pop = 1'b0;
    if (!flush_i && !buf_empty) begin
      unique case (1'b1)
        (state_q == ST_IDLE): pop = 1'b1;
        (state_q == ST_STREAM): pop = nib_ready_i && last && head_live;
        default: pop = 1'b0;
      endcase
    end
  end

  fifo_word_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .level_o (level_o)
  );

  // Unpacker FSM: load, advance through nibbles, chain or go idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nib_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (head_live) begin
            state_q <= ST_STREAM;
            idx_q   <= '0;
            word_q  <= head.data;
            cnt_q   <= head.cnt;
            nib_q   <= head.data[3:0];
          end
        end
        ST_STREAM: begin
          if (nib_ready_i) begin
            if (!last) begin
              idx_q <= idx_d;
              nib_q <= nib_d;
            end else if (head_live) begin
              idx_q  <= '0;
              word_q <= head.data;
              cnt_q  <= head.cnt;
              nib_q  <= head.data[3:0];
            end else begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
              nib_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          nib_q   <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_UNPACK_PAD_CHECK_EN
  logic pad_err_q;

  // Sticky flag: accepted word carried a non-pad nibble past its count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_err_q <= 1'b0;
    end else if (push && pad_bad(word_data_i, cnt_clamped)) begin
      pad_err_q <= 1'b1;
    end
  end

  assign pad_err_o = pad_err_q;
`else
  assign pad_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench for fifo_word_unpacker.
// Table vectors, directed corner sequences and a randomized model run.
module tb_fifo_word_unpacker;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FIFO_UNPACK_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_valid = 1'b0;
  logic [31:0]   word_data = '0;
  logic [3:0]    word_cnt = '0;
  logic          word_ready;
  logic          nib_valid;
  logic [3:0]    nib_data;
  logic          nib_ready = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] level;
  logic          pad_err;

  always #5 clk = ~clk;

  fifo_word_unpacker #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .word_valid_i (word_valid),
    .word_data_i  (word_data),
    .word_cnt_i   (word_cnt),
    .word_ready_o (word_ready),
    .nib_valid_o  (nib_valid),
    .nib_data_o   (nib_data),
    .nib_ready_i  (nib_ready),
    .flush_i      (flush),
    .fifo_empty_o (fifo_empty),
    .fifo_full_o  (fifo_full),
    .level_o      (level),
    .pad_err_o    (pad_err)
  );

  int checks = 0;
  int errors = 0;

  logic        acc;
  logic        xfer;
  logic [3:0]  xdata;
  logic [31:0] s_data;
  logic [3:0]  s_cnt;
  logic        s_flush;

  logic [3:0]  q[$];
  logic        pad_exp;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  cnt;
    int          exp_n;
    logic [31:0] exp_nibs;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc     = word_valid && word_ready;
    xfer    = nib_valid && nib_ready;
    xdata   = nib_data;
    s_data  = word_data;
    s_cnt   = word_cnt;
    s_flush = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    word_valid = 1'b0;
    nib_ready  = 1'b0;
    flush      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic collect(input int max_cyc, output int n,
                         output logic [31:0] nibs);
    n          = 0;
    nibs       = '0;
    nib_ready  = 1'b1;
    word_valid = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (xfer) begin
        if (n < 8) nibs[4*n +: 4] = xdata;
        n++;
      end
    end
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] c);
    word_data  = d;
    word_cnt   = c;
    word_valid = 1'b1;
  endtask

  // Reference model: a word becomes min(cnt,8) nibbles in order.
  task automatic model_accept(input logic [31:0] d, input logic [3:0] c);
    int n;
    n = (c > 4'd8) ? 8 : int'(c);
    for (int k = 0; k < 8; k++) begin
      if (k < n) q.push_back(d[4*k +: 4]);
      else if (PAD_EN && d[4*k +: 4] != 4'hC) pad_exp = 1'b1;
    end
  endtask

  initial begin
    int n;
    int got;
    int cyc;
    logic [31:0] nibs;
    logic [31:0] expv;
    logic [31:0] d;
    logic [3:0]  c;

    tbl[0] = '{32'h8765_4321, 4'd8,  8, 32'h8765_4321};
    tbl[1] = '{32'hCCCC_C321, 4'd3,  3, 32'h0000_0321};
    tbl[2] = '{32'hAAAA_AAAA, 4'd0,  0, 32'h0000_0000};
    tbl[3] = '{32'hFEDC_BA98, 4'd12, 8, 32'hFEDC_BA98};
    tbl[4] = '{32'hCCCC_CCC5, 4'd1,  1, 32'h0000_0005};
    tbl[5] = '{32'hCCC9_0E61, 4'd5,  5, 32'h0009_0E61};

    // Reset state, sampled while reset is still held.
    rst_n = 1'b0;
    step();
    step();
    chk("rst_nib_valid", nib_valid, 0);
    chk("rst_nib_data", nib_data, 0);
    chk("rst_word_ready", word_ready, 1);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", level, 0);
    chk("rst_pad_err", pad_err, 0);
    rst_n = 1'b1;

    // Table vectors: one word each, drained with ready held high.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      put(tbl[i].data, tbl[i].cnt);
      step();
      chk("tbl_accept", acc, 1);
      collect(14, n, nibs);
      chk($sformatf("tbl%0d_count", i), n, tbl[i].exp_n);
      chk($sformatf("tbl%0d_nibs", i), nibs, tbl[i].exp_nibs);
      chk($sformatf("tbl%0d_empty", i), fifo_empty, 1);
    end

    // Latency and sustained rate for a full word.
    do_reset();
    nib_ready = 1'b1;
    put(32'h8765_4321, 4'd8);
    step();
    chk("lat_accept", acc, 1);
    chk("lat_not_yet", nib_valid, 0);
    word_valid = 1'b0;
    step();
    expv = 32'h8765_4321;
    for (int k = 0; k < 8; k++) begin
      chk("seq_valid", nib_valid, 1);
      chk("seq_data", nib_data, expv[4*k +: 4]);
      step();
    end
    chk("seq_done_valid", nib_valid, 0);
    chk("seq_done_empty", fifo_empty, 1);

    // Back-to-back words chain without a bubble.
    do_reset();
    nib_ready = 1'b1;
    put(32'hCCCC_C321, 4'd3);
    step();
    put(32'hCCCC_CCBA, 4'd2);
    step();
    word_valid = 1'b0;
    expv = 32'h000B_A321;
    for (int k = 0; k < 5; k++) begin
      chk("b2b_valid", nib_valid, 1);
      chk("b2b_data", nib_data, expv[4*k +: 4]);
      step();
    end
    chk("b2b_end", nib_valid, 0);
    chk("b2b_pad", pad_err, 0);

    // Fill: one word in the unpacker, DEPTH buffered, sixth held off.
    do_reset();
    got = 0;
    put(32'hCCCC_CCC1, 4'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (acc) begin
        got++;
        word_data = 32'hCCCC_CCC0 + 32'(got + 1);
      end
    end
    chk("full_accepted", got, 5);
    chk("full_flag", fifo_full, 1);
    chk("full_ready", word_ready, 0);
    chk("full_level", level, 4);
    chk("full_nib", nib_data, 1);
    nib_ready = 1'b1;
    step();
    chk("full_no_wt", acc, 0);
    chk("full_xfer", xfer, 1);
    nib_ready = 1'b0;
    step();
    chk("sixth_accept", acc, 1);
    word_valid = 1'b0;

    // Flush mid-stream with three words buffered.
    do_reset();
    put(32'h8765_4321, 4'd8);
    for (int k = 0; k < 4; k++) step();
    word_valid = 1'b0;
    chk("fl_level_pre", level, 3);
    nib_ready = 1'b1;
    step();
    chk("fl_xfer", xfer, 1);
    flush = 1'b1;
    #1;
    chk("fl_ready_low", word_ready, 0);
    step();
    flush = 1'b0;
    nib_ready = 1'b0;
    chk("fl_valid", nib_valid, 0);
    chk("fl_level", level, 0);
    chk("fl_empty", fifo_empty, 1);
    put(32'h1234_5678, 4'd8);
    step();
    word_valid = 1'b0;
    step();
    chk("fl_new_valid", nib_valid, 1);
    chk("fl_new_nib0", nib_data, 8);

    // Reset mid-stream discards everything.
    do_reset();
    nib_ready = 1'b1;
    put(32'h8765_4321, 4'd8);
    step();
    step();
    step();
    word_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (xfer || nib_valid) got++;
    end
    chk("rst_mid_quiet", got, 0);
    chk("rst_mid_empty", fifo_empty, 1);

    // Pad check on a short word with non-pad filler.
    do_reset();
    put(32'h0000_0021, 4'd2);
    step();
    word_valid = 1'b0;
    chk("pad_set", pad_err, PAD_EN);
    collect(6, n, nibs);
    chk("pad_nibs", nibs, 32'h21);
    chk("pad_count", n, 2);
    chk("pad_sticky", pad_err, PAD_EN);
    do_reset();
    chk("pad_cleared", pad_err, 0);

    // Randomized traffic against the nibble-queue model.
    do_reset();
    q.delete();
    pad_exp = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      c = 4'($urandom_range(0, 12));
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (k >= int'(c)) d[4*k +: 4] = 4'hC;
        end
      end
      word_data  = d;
      word_cnt   = c;
      word_valid = ($urandom_range(0, 9) < 6);
      nib_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 99) < 2);
      step();
      if (xfer) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          chk("rnd_nib", xdata, q.pop_front());
        end
      end
      if (s_flush) q.delete();
      if (acc) model_accept(s_data, s_cnt);
      chk("rnd_valid_has_data", nib_valid && (q.size() == 0), 0);
      chk("rnd_empty_consistent", fifo_empty && (q.size() != 0), 0);
      chk("rnd_pad", pad_err, pad_exp);
    end

    // Drain whatever remains, bounded.
    flush      = 1'b0;
    word_valid = 1'b0;
    nib_ready  = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || !fifo_empty) && cyc < 300) begin
      step();
      cyc++;
      if (xfer) begin
        if (q.size() == 0) chk("drain_spurious", 1, 0);
        else chk("drain_nib", xdata, q.pop_front());
      end
    end
    chk("drain_left", q.size(), 0);
    chk("drain_empty", fifo_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
